// File: rtl/fdiv_pipe_ctrl.sv
// fdiv_pipe_ctrl: issue/flow controller for the divide pipeline, per-stage enables, tags, response handshake.
// Optional FDIV_FLUSH_EN adds a flush input that discards all in-flight operations.
module fdiv_pipe_ctrl #(
  parameter int DEPTH = 5,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic [DEPTH-1:0] stg_en,
  input  logic [31:0]      res_data,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  input  logic             rsp_ready,
  output logic [2:0]       occupancy,
  output logic [CNT_W-1:0] done_cnt
`ifdef FDIV_FLUSH_EN
  ,
  input  logic             flush
`endif
);
  logic [DEPTH-1:0] v, en, v_in;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [TAG_W-1:0] tag_in [DEPTH];
  logic fl, run, accept, fire;
`ifdef FDIV_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  // A stage stalls only when it and every stage downstream are full and writeback is not consuming.
  always_comb begin
    run = 1'b1;
    en = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run = run & v[i];
      en[i] = rsp_ready | !run;
    end
  end
  assign stg_en    = !rst ? '0 : fl ? '1 : en;
  assign req_ready = rst & !fl & en[0];
  assign rsp_valid = rst & !fl & v[DEPTH-1];
  assign rsp_tag   = tag[DEPTH-1];
  assign rsp_data  = res_data;
  assign accept    = req_valid & req_ready;
  assign fire      = rsp_valid & rsp_ready;
  assign v_in      = {v[DEPTH-2:0], accept};
  always_comb begin
    tag_in[0] = req_tag;
    for (int i = 1; i < DEPTH; i++) tag_in[i] = tag[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= '0;
      occupancy <= '0;
      done_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else if (fl) begin
      v <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          v[i] <= v_in[i];
          tag[i] <= tag_in[i];
        end
      end
      occupancy <= occupancy + 3'(accept) - 3'(fire);
      done_cnt <= done_cnt + CNT_W'(fire & ~&done_cnt);
    end
  end
endmodule

// File: tb/tb_fdiv_pipe_ctrl.sv
// tb_fdiv_pipe_ctrl: random and directed stimulus checked against an op-queue model of the pipeline.
module tb_fdiv_pipe_ctrl;
  localparam int D = 5, TW = 5, CW = 16;
`ifdef FDIV_FLUSH_EN
  localparam bit HAS_FL = 1'b1;
`else
  localparam bit HAS_FL = 1'b0;
`endif
  logic clk = 0, rst = 0, req_valid = 0, rsp_ready = 0, flush = 0;
  logic [TW-1:0] req_tag = 0;
  logic [31:0] res_data = 0;
  logic req_ready, rsp_valid;
  logic [D-1:0] stg_en;
  logic [TW-1:0] rsp_tag;
  logic [31:0] rsp_data;
  logic [2:0] occupancy;
  logic [CW-1:0] done_cnt;
  fdiv_pipe_ctrl #(.DEPTH(D), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .stg_en(stg_en), .res_data(res_data), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .occupancy(occupancy), .done_cnt(done_cnt)
`ifdef FDIV_FLUSH_EN
    , .flush(flush)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [TW-1:0] tag; int pos;} op_t;
  op_t q[$];
  int cnt = 0, total = 0, bad = 0;
  bit live = 0, prev_rst = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit fl();
    return HAS_FL && flush;
  endfunction
  // Stage i is blocked iff every position from i to the end holds an op.
  function automatic bit full_from(int i);
    int c = 0;
    foreach (q[k]) if (q[k].pos >= i) c++;
    return c == D - i;
  endfunction
  function automatic bit head_out();
    return q.size() > 0 && q[0].pos == D - 1;
  endfunction
  task automatic compare();
    logic [D-1:0] e;
    if (!live) return;
    chk("occupancy", occupancy, q.size());
    chk("done_cnt", done_cnt, cnt);
    chk("rsp_data", rsp_data, res_data);
    if (!rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_stg_en", stg_en, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      if (prev_rst) chk("rst_rsp_tag", rsp_tag, 0);
    end else if (fl()) begin
      chk("fl_req_ready", req_ready, 0);
      chk("fl_rsp_valid", rsp_valid, 0);
      chk("fl_stg_en", stg_en, {D{1'b1}});
    end else begin
      for (int i = 0; i < D; i++) e[i] = rsp_ready | !full_from(i);
      chk("stg_en", stg_en, e);
      chk("req_ready", req_ready, e[0]);
      chk("rsp_valid", rsp_valid, head_out());
      if (head_out()) chk("rsp_tag", rsp_tag, q[0].tag);
    end
  endtask
  task automatic upd();
    bit rr;
    if (!rst) begin
      q.delete();
      cnt = 0;
      live = 1;
      prev_rst = 1;
      return;
    end
    prev_rst = 0;
    if (fl()) begin
      q.delete();
      return;
    end
    rr = rsp_ready | !full_from(0);
    if (head_out() && rsp_ready) begin
      void'(q.pop_front());
      if (cnt < 65535) cnt++;
    end
    for (int k = 0; k < q.size(); k++)
      if (q[k].pos < D - 1 && !(k > 0 && q[k-1].pos == q[k].pos + 1)) q[k].pos = q[k].pos + 1;
    if (req_valid && rr) q.push_back('{req_tag, 0});
  endtask
  task automatic settle();
    #1 compare();
  endtask
  task automatic tick();
    @(posedge clk);
    upd();
    @(negedge clk);
  endtask
  task automatic step();
    settle();
    tick();
  endtask
  task automatic idle(int n);
    req_valid = 0;
    rsp_ready = 1;
    for (int c = 0; c < n; c++) step();
  endtask
  int nt;
  initial begin
    rst = 0;
    req_valid = 1;
    for (int c = 0; c < 3; c++) step();
    settle();
    chk("hold_req_ready", req_ready, 0);
    chk("hold_occ", occupancy, 0);
    rst = 1;
    req_valid = 0;
    tick();
    settle();
    chk("rel_req_ready", req_ready, 1);
    chk("rel_stg_en", stg_en, 5'b11111);
    rsp_ready = 1;
    for (int c = 0; c < 10; c++) begin
      req_valid = c < 5;
      req_tag = TW'(c + 1);
      res_data = $urandom;
      settle();
      chk("b2b_valid", rsp_valid, c >= 5);
      if (c >= 5) chk("b2b_tag", rsp_tag, c - 4);
      tick();
    end
    req_valid = 0;
    settle();
    chk("b2b_cnt", done_cnt, 5);
    rsp_ready = 0;
    req_valid = 1;
    nt = 1;
    for (int c = 0; c < 7; c++) begin
      req_tag = TW'(nt);
      settle();
      if (req_ready) nt++;
      tick();
    end
    req_tag = TW'(nt);
    settle();
    chk("bp_accepted", nt - 1, 5);
    chk("bp_occ", occupancy, 5);
    chk("bp_req_ready", req_ready, 0);
    rsp_ready = 1;
    settle();
    chk("bp_fire_tag", rsp_tag, 1);
    chk("bp_req_ready_hi", req_ready, 1);
    tick();
    req_valid = 0;
    settle();
    chk("bp_occ_same", occupancy, 5);
    idle(8);
    for (int c = 0; c < 8; c++) begin
      req_valid = c == 0 || c == 2;
      req_tag = c == 0 ? 5'd1 : 5'd2;
      rsp_ready = c < 4;
      step();
    end
    settle();
    chk("bub_stg_en", stg_en, 5'b00111);
    chk("bub_occ", occupancy, 2);
    chk("bub_tag", rsp_tag, 1);
    idle(6);
    for (int c = 0; c < 3; c++) begin
      req_valid = 1;
      req_tag = TW'(c + 3);
      step();
    end
    req_valid = 0;
    rst = 0;
    step();
    rst = 1;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("mid_rst_no_rsp", rsp_valid, 0);
      tick();
    end
    chk("mid_rst_occ", occupancy, 0);
`ifdef FDIV_FLUSH_EN
    for (int c = 0; c < 4; c++) begin
      req_valid = 1;
      req_tag = TW'(c + 10);
      step();
    end
    flush = 1;
    rsp_ready = 1;
    req_tag = 5'd20;
    settle();
    chk("fl_no_accept", req_ready, 0);
    chk("fl_no_fire", rsp_valid, 0);
    tick();
    flush = 0;
    req_tag = 5'd9;
    settle();
    chk("fl_occ", occupancy, 0);
    tick();
    req_valid = 0;
    for (int c = 1; c < D; c++) step();
    settle();
    chk("fl_new_valid", rsp_valid, 1);
    chk("fl_new_tag", rsp_tag, 9);
    tick();
`endif
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      req_valid = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 2) != 0;
      req_tag = TW'($urandom);
      res_data = $urandom;
      flush = HAS_FL && $urandom_range(0, 49) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fdiv_pipe_ctrl.md
# fdiv_pipe_ctrl

Issue and flow controller for the 5-stage single-precision divide pipeline (stages p1..p5; p5 packs sign/exponent/mantissa into the IEEE 754 result). It accepts divide requests from the FPU issue logic over a valid/ready handshake. It drives per-stage enables so the pipeline advances, stalls and collapses bubbles. It tracks a valid bit and destination tag per stage and presents the p5 result with its tag on a valid/ready response port to writeback.

## Interface
Parameters:
- DEPTH, 5, number of datapath stages controlled (p1..pDEPTH); stage index 0 = p1.
- TAG_W, 5, destination-register tag width carried alongside each operation.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- req_valid  in  1  issue request present.
- req_tag  in  TAG_W  destination tag of request.
- req_ready  out  1  controller accepts request this cycle.
- stg_en  out  DEPTH  per-stage register enable to datapath; bit i loads stage i from stage i-1 (bit 0 loads operands).
- res_data  in  32  packed result from last stage (pDEPTH output register).
- rsp_valid  out  1  result available.
- rsp_tag  out  TAG_W  tag of presented result.
- rsp_data  out  32  equals res_data.
- rsp_ready  in  1  writeback consumes result.
- occupancy  out  3  number of valid stages, 0..DEPTH.
- done_cnt  out  CNT_W  saturating count of completed responses.
- flush  in  1  only with FDIV_FLUSH_EN; discard all in-flight ops.

## Operation
- State: v[DEPTH-1:0] valid bits; tag[i] per stage; occupancy register; done_cnt register.
- Enable chain (combinational): en[DEPTH-1] = !v[DEPTH-1] | rsp_ready; en[i] = !v[i] | en[i+1] for i < DEPTH-1. stg_en = en.
- req_ready = en[0] (0 while rst low). Accept = req_valid & req_ready.
- On edge, for each i with en[i]: v[0] <= accept and tag[0] <= req_tag; v[i] <= v[i-1] and tag[i] <= tag[i-1] for i > 0. Stages with en[i]=0 hold.
- A stall propagates upstream only through full stages. Empty stages always load, so bubbles collapse.
- rsp_valid = v[DEPTH-1]; rsp_tag = tag[DEPTH-1]; rsp_data = res_data. Response fires when rsp_valid & rsp_ready.
- occupancy <= occupancy + accept - fire. Value equals popcount(v), never exceeds DEPTH.
- done_cnt increments on fire and saturates at all-ones.
- Results are returned strictly in issue order. No reordering occurs.
- Controller does not inspect operand or result data.

## Timing
- Reset (rst=0 at edge): v=0, tag=0, occupancy=0, done_cnt=0. During and after reset: rsp_valid=0, rsp_tag=0. While rst=0: req_ready=0 and stg_en=0. First cycle after reset: req_ready=1, stg_en all ones.
- Latency: a request accepted in cycle T appears with rsp_valid=1 in cycle T+DEPTH when unstalled.
- Throughput: 1 accept/cycle sustained while rsp_ready=1.
- Full pipe with rsp_ready=0: req_ready=0. Same cycle rsp_ready=1: req_ready=1, and accept plus fire occur together (occupancy unchanged).
- Combinational path rsp_ready -> stg_en -> req_ready is intentional; depth is DEPTH gates.
- Reset mid-operation: all in-flight ops are dropped with no response, and the counter clears.

## Configuration
- FDIV_FLUSH_EN defined: flush port exists. In a cycle with flush=1: req_ready=0, rsp_valid=0 (no accept, no fire, done_cnt unchanged), stg_en all ones. At the edge, v cleared and occupancy set to 0; tags are don't-care. Normal operation resumes the next cycle. rst has priority over flush.
- Undefined: no flush port. In-flight ops are only discarded by rst.

## Test plan
- Reset: hold rst=0 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, occupancy=0, done_cnt=0. Release -> req_ready=1 next cycle.
- Back-to-back: issue tags 1..5 in cycles 0..4 with rsp_ready=1 -> rsp_valid cycles 5..9 with tags 1..5 in order, rsp_data matching res_data, done_cnt=5.
- Backpressure: rsp_ready=0, req_valid=1 continuously with tags 1..7 -> exactly 5 accepted (occupancy=5, req_ready=0). Raise rsp_ready -> tag 1 fires and tag 6 is accepted the same cycle.
- Bubble collapse: issue tag 1 at cycle 0, idle, tag 2 at cycle 2, rsp_ready=0 from cycle 4 -> tag 2 advances until directly behind tag 1 (v=5'b11000), stg_en[4:3]=0.
- Reset mid-op: 3 ops in flight, rst=0 one cycle -> no responses ever emerge, occupancy=0.
- Flush (FDIV_FLUSH_EN): 4 ops in flight, flush=1 with req_valid=1 and rsp_ready=1 -> no accept, no fire, v=0 next cycle. A new request is then returned after DEPTH cycles with the correct tag.
